// File: rtl/dcpu16_pkg.sv
// ============================================================================
//  Module      : dcpu16_pkg
//  Description : Shared constants and helpers for the DCPU16 bus arbiter.
//                Optional feature macro used by dcpu16_arb: DCPU16_ARB_RR_EN.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package dcpu16_pkg;

    localparam int DEF_AW = 16;
    localparam int DEF_DW = 16;

    localparam logic [1:0] ARB_IDLE = 2'd0;
    localparam logic [1:0] ARB_BUSY = 2'd1;
    localparam logic [1:0] ARB_ACK  = 2'd2;

    // Index width that stays at least one bit wide for degenerate sizes.
    function automatic int clog2_min1(input int v);
        return (v <= 2) ? 1 : $clog2(v);
    endfunction

endpackage

`default_nettype wire

// File: rtl/dcpu16_arb_pick.sv
// ============================================================================
//  Module      : dcpu16_arb_pick
//  Description : Combinational N-wide picker; first request at or after the
//                start index (wrapping) wins, giving one-hot grant and index.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module dcpu16_arb_pick
    import dcpu16_pkg::*;
#(
    parameter int NM = 2,
    parameter int IW = clog2_min1(NM)
) (
    input  logic [NM-1:0] req,
    input  logic [IW-1:0] start,
    output logic [NM-1:0] gnt,
    output logic [IW-1:0] idx,
    output logic          any
);

    int              pos;
    logic [NM-1:0]   w_hit;

    // Scan farthest-first so the closest request to start overwrites last.
    always_comb begin
        gnt   = '0;
        idx   = '0;
        pos   = 0;
        w_hit = '0;
        any   = |req;
        for (int k = NM - 1; k >= 0; k--) begin
            pos   = (int'(start) + k) % NM;
            w_hit = req >> pos;
            if (w_hit[0]) begin
                gnt = NM'(1) << pos;
                idx = IW'(pos);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/dcpu16_arb.sv
// ============================================================================
//  Module      : dcpu16_arb
//  Description : N-master stb/ack bus arbiter onto one memory slave with a
//                slave-timeout watchdog. Define DCPU16_ARB_RR_EN for
//                round-robin; otherwise lowest index has fixed priority.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module dcpu16_arb
    import dcpu16_pkg::*;
#(
    parameter int NM  = 2,
    parameter int AW  = DEF_AW,
    parameter int DW  = DEF_DW,
    parameter int TMO = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NM-1:0]    m_stb,
    input  logic [NM-1:0]    m_wre,
    input  logic [NM*AW-1:0] m_adr,
    input  logic [NM*DW-1:0] m_dto,
    output logic [NM-1:0]    m_ack,
    output logic [NM-1:0]    m_err,
    output logic [DW-1:0]    m_dti,
    output logic             s_stb,
    output logic             s_wre,
    output logic [AW-1:0]    s_adr,
    output logic [DW-1:0]    s_dto,
    input  logic [DW-1:0]    s_dti,
    input  logic             s_ack
);

    localparam int            IW    = clog2_min1(NM);
    localparam int            CW    = clog2_min1(TMO + 1);
    localparam logic [CW-1:0] C_TMO = CW'(TMO);

    logic [1:0]    r_state;
    logic [NM-1:0] r_gnt;
    logic [CW-1:0] r_cnt;
    logic [IW-1:0] w_start;
    logic [IW-1:0] w_idx;
    logic [NM-1:0] w_gnt;
    logic          w_any;
    logic          w_tmo;

`ifdef DCPU16_ARB_RR_EN
    logic [IW-1:0] r_ptr;

    assign w_start = (r_ptr == IW'(NM - 1)) ? '0 : r_ptr + 1'b1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ptr <= IW'(NM - 1);
        end else if (r_state == ARB_IDLE && w_any) begin
            r_ptr <= w_idx;
        end
    end
`else
    assign w_start = '0;
`endif

    dcpu16_arb_pick #(
        .NM (NM),
        .IW (IW)
    ) u_pick (
        .req   (m_stb),
        .start (w_start),
        .gnt   (w_gnt),
        .idx   (w_idx),
        .any   (w_any)
    );

    assign w_tmo = (TMO != 0) && (r_cnt == C_TMO);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ARB_IDLE;
            r_gnt   <= '0;
            r_cnt   <= '0;
            m_ack   <= '0;
            m_err   <= '0;
            m_dti   <= '0;
            s_stb   <= 1'b0;
            s_wre   <= 1'b0;
            s_adr   <= '0;
            s_dto   <= '0;
        end else begin
            case (r_state)
                ARB_IDLE: begin
                    if (w_any) begin
                        s_stb   <= 1'b1;
                        s_wre   <= m_wre[w_idx];
                        s_adr   <= m_adr[w_idx*AW +: AW];
                        s_dto   <= m_dto[w_idx*DW +: DW];
                        r_gnt   <= w_gnt;
                        r_cnt   <= '0;
                        r_state <= ARB_BUSY;
                    end
                end
                ARB_BUSY: begin
                    if (s_ack) begin
                        s_stb   <= 1'b0;
                        m_ack   <= r_gnt;
                        m_err   <= '0;
                        m_dti   <= s_dti;
                        r_state <= ARB_ACK;
                    end else if (w_tmo) begin
                        s_stb   <= 1'b0;
                        m_ack   <= r_gnt;
                        m_err   <= r_gnt;
                        m_dti   <= '0;
                        r_state <= ARB_ACK;
                    end else if (r_cnt != C_TMO) begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                // One-cycle ack slot keeps a stale strobe from being re-granted.
                ARB_ACK: begin
                    m_ack   <= '0;
                    m_err   <= '0;
                    r_state <= ARB_IDLE;
                end
                default: begin
                    r_state <= ARB_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire
